// File: rtl/div_iter_clz.sv
// div_iter_clz: multi-cycle 32-bit DIV/DIVU unit with leading-zero skipping.
// The dividend magnitude (dvd_abs) drives an external clz instance. Its count
// (clz_in) lets the restoring loop skip the dividend's leading zero bits.
// Quotient goes to LO (q) and remainder goes to HI (r).
// Build option DIV_EARLY_TERM_EN:
//   defined   -> iteration count is 32 - clz_in and the dividend is pre-shifted.
//   undefined -> clz_in is ignored and the loop always runs 32 steps.
module div_iter_clz #(
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     is_signed,
    input  logic [WIDTH-1:0]         dividend,
    input  logic [WIDTH-1:0]         divisor,
    output logic [WIDTH-1:0]         dvd_abs,
    input  logic [$clog2(WIDTH):0]   clz_in,
    output logic                     busy,
    output logic                     done,
    output logic [WIDTH-1:0]         q,
    output logic [WIDTH-1:0]         r
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, PREP, CALC, FIX} state_t;

    state_t           state, state_nx;

    logic [WIDTH-1:0] dvd_raw;   // unmodified dividend, returned as r on divide-by-zero
    logic [WIDTH-1:0] dsr_abs;   // divisor magnitude
    logic             dvd_neg;   // signed op with a negative dividend
    logic             dsr_neg;   // signed op with a negative divisor
    logic [WIDTH-1:0] dvd;       // shifting dividend; collects quotient bits at the LSB
    logic [WIDTH-1:0] rem;       // partial remainder
    logic [CW-1:0]    cnt;       // restoring steps still to do

    logic [CW-1:0]    iter_n;
    logic [CW-1:0]    shamt;
    logic             zero_dvd;
    logic             zero_dsr;

    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   rem_sub;
    logic             rem_ge;
    logic [WIDTH-1:0] rem_nx;
    logic [WIDTH-1:0] q_fix;
    logic [WIDTH-1:0] r_fix;

`ifdef DIV_EARLY_TERM_EN
    // Skip the leading zeros: only the significant bits are iterated.
    assign iter_n   = CW'(WIDTH) - clz_in;
    assign shamt    = clz_in;
    assign zero_dvd = (iter_n == '0);
`else
    // Fixed-latency build: full-width loop. clz_in is deliberately unused.
    logic clz_unused;
    assign clz_unused = ^clz_in;
    assign iter_n     = CW'(WIDTH);
    assign shamt      = '0;
    assign zero_dvd   = (dvd_abs == '0);
`endif

    assign zero_dsr = (dsr_abs == '0);

    // One restoring step. The compare and subtract are WIDTH+1 bits wide, so the
    // shifted remainder can never overflow. The sign bit of the difference is the borrow.
    assign rem_sh  = {rem, dvd[WIDTH-1]};
    assign rem_sub = rem_sh - {1'b0, dsr_abs};
    assign rem_ge  = ~rem_sub[WIDTH];
    assign rem_nx  = rem_ge ? rem_sub[WIDTH-1:0] : rem_sh[WIDTH-1:0];

    // Sign correction. The quotient sign is the XOR of the operand signs.
    // The remainder follows the dividend's sign.
    assign q_fix = (dvd_neg ^ dsr_neg) ? -dvd : dvd;
    assign r_fix = dvd_neg ? -rem : rem;

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Next-state logic.
    always_comb begin
        // NOTE: default first so no path through this block leaves state_nx unassigned (no latch).
        state_nx = state;
        unique case (state)
            IDLE: if (start) state_nx = PREP;
            PREP: state_nx = (zero_dsr || zero_dvd) ? FIX : CALC;
            CALC: if (cnt == CW'(1)) state_nx = FIX;
            FIX:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Datapath: latch operands, prepare the loop, iterate, then correct signs and publish.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy    <= 1'b0;
            done    <= 1'b0;
            q       <= '0;
            r       <= '0;
            dvd_abs <= '0;
            dvd_raw <= '0;
            dsr_abs <= '0;
            dvd_neg <= 1'b0;
            dsr_neg <= 1'b0;
            dvd     <= '0;
            rem     <= '0;
            cnt     <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        busy    <= 1'b1;
                        dvd_raw <= dividend;
                        dvd_neg <= is_signed & dividend[WIDTH-1];
                        dsr_neg <= is_signed & divisor[WIDTH-1];
                        dvd_abs <= (is_signed && dividend[WIDTH-1]) ? -dividend : dividend;
                        dsr_abs <= (is_signed && divisor[WIDTH-1])  ? -divisor  : divisor;
                    end
                end
                PREP: begin
                    if (zero_dsr) begin
                        // Divide by zero returns all-ones and the raw dividend, with no sign fix.
                        dvd     <= '1;
                        rem     <= dvd_raw;
                        dvd_neg <= 1'b0;
                        dsr_neg <= 1'b0;
                    end else if (zero_dvd) begin
                        dvd <= '0;
                        rem <= '0;
                    end else begin
                        dvd <= dvd_abs << shamt;
                        rem <= '0;
                        cnt <= iter_n;
                    end
                end
                CALC: begin
                    rem <= rem_nx;
                    dvd <= {dvd[WIDTH-2:0], rem_ge};
                    cnt <= cnt - CW'(1);
                end
                FIX: begin
                    q    <= q_fix;
                    r    <= r_fix;
                    done <= 1'b1;
                    busy <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_div_iter_clz.sv
// Directed bench for div_iter_clz. It models the external clz driven by dvd_abs.
// Expected latency follows the DIV_EARLY_TERM_EN build selection.
module tb_div_iter_clz;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        is_signed;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic [31:0] dvd_abs;
    logic [5:0]  clz_in;
    logic        busy;
    logic        done;
    logic [31:0] q;
    logic [31:0] r;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    div_iter_clz dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .is_signed (is_signed),
        .dividend  (dividend),
        .divisor   (divisor),
        .dvd_abs   (dvd_abs),
        .clz_in    (clz_in),
        .busy      (busy),
        .done      (done),
        .q         (q),
        .r         (r)
    );

    // External count-leading-zeros unit (0..32).
    function automatic logic [5:0] clz32(input logic [31:0] v);
        logic [5:0] n;
        n = 6'd32;
        for (int i = 0; i < 32; i++)
            if (v[i]) n = 6'(31 - i);
        return n;
    endfunction

    assign clz_in = clz32(dvd_abs);

    function automatic logic [31:0] mag(input logic sg, input logic [31:0] v);
        return (sg && v[31]) ? -v : v;
    endfunction

    // Edges from the start edge (counted as 1) to the edge that raises done.
    function automatic int exp_lat(input logic sg, input logic [31:0] a, input logic [31:0] b);
        if (b == 32'd0 || a == 32'd0) return 3;
`ifdef DIV_EARLY_TERM_EN
        return 32 - int'(clz32(mag(sg, a))) + 3;
`else
        return 35;
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one division. Scramble the operands while busy, wait for done
    // with a bound, then check the result, the latency and the done pulse width.
    task automatic run_div(input string tag, input logic sg, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] eq, input logic [31:0] er);
        int edges;
        is_signed = sg;
        dividend  = a;
        divisor   = b;
        start     = 1'b1;
        @(posedge clk); #1;
        start     = 1'b0;
        is_signed = ~sg;
        dividend  = ~a;
        divisor   = b ^ 32'h5A5A_0001;
        edges     = 1;
        check({tag, " busy_after_start"}, {31'd0, busy}, 32'd1);
        check({tag, " dvd_abs"}, dvd_abs, mag(sg, a));
        while (done !== 1'b1 && edges < 100) begin
            @(posedge clk); #1;
            edges++;
        end
        check({tag, " latency"}, 32'(edges), 32'(exp_lat(sg, a, b)));
        check({tag, " q"}, q, eq);
        check({tag, " r"}, r, er);
        check({tag, " busy_at_done"}, {31'd0, busy}, 32'd0);
        @(posedge clk); #1;
        check({tag, " done_pulse"}, {31'd0, done}, 32'd0);
        check({tag, " q_hold"}, q, eq);
    endtask

    initial begin
        int edges;
        int done_seen;

        rst_n     = 1'b0;
        start     = 1'b0;
        is_signed = 1'b0;
        dividend  = 32'd0;
        divisor   = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset done", {31'd0, done}, 32'd0);
        check("reset q", q, 32'd0);
        check("reset r", r, 32'd0);
        check("reset dvd_abs", dvd_abs, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Hand-computed vectors: tag, signed, dividend, divisor, q, r.
        run_div("divu_100_7",      1'b0, 32'd100,       32'd7,         32'd14,        32'd2);
        run_div("div_m100_7",      1'b1, 32'hFFFFFF9C,  32'd7,         32'hFFFFFFF2,  32'hFFFFFFFE);
        run_div("div_100_m7",      1'b1, 32'd100,       32'hFFFFFFF9,  32'hFFFFFFF2,  32'd2);
        run_div("div_min_m1",      1'b1, 32'h80000000,  32'hFFFFFFFF,  32'h80000000,  32'd0);
        run_div("divu_5_0",        1'b0, 32'd5,         32'd0,         32'hFFFFFFFF,  32'd5);
        run_div("divu_0_9",        1'b0, 32'd0,         32'd9,         32'd0,         32'd0);
        run_div("div_m5_0",        1'b1, 32'hFFFFFFFB,  32'd0,         32'hFFFFFFFF,  32'hFFFFFFFB);
        run_div("divu_max_1",      1'b0, 32'hFFFFFFFF,  32'd1,         32'hFFFFFFFF,  32'd0);
        run_div("divu_7_100",      1'b0, 32'd7,         32'd100,       32'd0,         32'd7);
        run_div("div_m7_m2",       1'b1, 32'hFFFFFFF9,  32'hFFFFFFFE,  32'd3,         32'hFFFFFFFF);
        run_div("divu_min_max",    1'b0, 32'h80000000,  32'hFFFFFFFF,  32'd0,         32'h80000000);
        run_div("divu_1_1",        1'b0, 32'd1,         32'd1,         32'd1,         32'd0);
        run_div("div_min_1",       1'b1, 32'h80000000,  32'd1,         32'h80000000,  32'd0);
        run_div("divu_deadbeef_16",1'b0, 32'hDEADBEEF,  32'd16,        32'h0DEADBEE,  32'd15);

        // Start pulsed mid-CALC with new operands must be ignored.
        is_signed = 1'b0; dividend = 32'd100; divisor = 32'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        edges = 1;
        repeat (2) begin @(posedge clk); #1; edges++; end
        is_signed = 1'b1; dividend = 32'd1000; divisor = 32'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        edges++;
        while (done !== 1'b1 && edges < 100) begin
            @(posedge clk); #1;
            edges++;
        end
        check("midcalc_start latency", 32'(edges), 32'(exp_lat(1'b0, 32'd100, 32'd7)));
        check("midcalc_start q", q, 32'd14);
        check("midcalc_start r", r, 32'd2);
        @(posedge clk); #1;
        check("midcalc_start no_restart", {31'd0, busy}, 32'd0);

        // Start held across the done edge is taken on the following edge only.
        is_signed = 1'b0; dividend = 32'd5; divisor = 32'd0; start = 1'b1;
        @(posedge clk); #1;                 // edge 1: PREP
        start = 1'b0;
        @(posedge clk); #1;                 // edge 2: FIX
        dividend = 32'd0; divisor = 32'd9; start = 1'b1;
        @(posedge clk); #1;                 // edge 3: done, back to IDLE
        check("back2back done1", {31'd0, done}, 32'd1);
        check("back2back q1", q, 32'hFFFFFFFF);
        check("back2back busy_idle", {31'd0, busy}, 32'd0);
        @(posedge clk); #1;                 // edge 4: second start accepted
        start = 1'b0;
        check("back2back busy2", {31'd0, busy}, 32'd1);
        check("back2back done_low", {31'd0, done}, 32'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;                 // third edge of the second op
        check("back2back done2", {31'd0, done}, 32'd1);
        check("back2back q2", q, 32'd0);
        check("back2back r2", r, 32'd0);
        @(posedge clk); #1;

        // Reset mid-CALC discards the operation and clears the outputs.
        is_signed = 1'b0; dividend = 32'hDEADBEEF; divisor = 32'd16; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("midcalc_reset busy_before", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("midcalc_reset busy", {31'd0, busy}, 32'd0);
        check("midcalc_reset done", {31'd0, done}, 32'd0);
        check("midcalc_reset q", q, 32'd0);
        check("midcalc_reset r", r, 32'd0);
        check("midcalc_reset dvd_abs", dvd_abs, 32'd0);
        rst_n = 1'b1;
        done_seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done === 1'b1) done_seen++;
        end
        check("midcalc_reset no_done", 32'(done_seen), 32'd0);
        check("midcalc_reset idle", {31'd0, busy}, 32'd0);

        // Operation after reset still works.
        run_div("post_reset_div_m100_m7", 1'b1, 32'hFFFFFF9C, 32'hFFFFFFF9, 32'd14, 32'hFFFFFFFE);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
